ch_seq_ctrl: RTL

Sequencer for the per-channel delay counters of the delay signal generator. It holds per-channel delay codes, a channel enable mask and a repeat period, and on an external trigger loads the counters and fires their start strobes. It then collects per-channel completion and clears the channels. It sits between the configuration interface and the channel counter array, and supports single-shot (GZI) and periodic re-fire (GVI) operation.

---
 rtl/ch_seq_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ch_seq_ctrl.sv
// Channel sequencer: arm/trigger handshake, shadow load of delay codes, start strobes,
// completion collection with timeout, and optional periodic re-fire.
module ch_seq_ctrl #(
  parameter int NCH = 4,
  parameter int DW  = 16,
  parameter int TMO = 65536
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [3:0]        i_wr_addr,
  input  logic [DW-1:0]     i_wr_data,
  input  logic              i_arm,
  input  logic              i_trig,
  input  logic              i_abort,
  input  logic [NCH-1:0]    i_ch_done,
  output logic [NCH*DW-1:0] o_ch_data,
  output logic [NCH-1:0]    o_ch_en,
  output logic [NCH-1:0]    o_ch_start,
  output logic              o_ch_clr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic              o_err,
  output logic [2:0]        o_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_FIRE  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  localparam int             TW       = $clog2(TMO);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TMO - 1);
  localparam logic [DW-1:0]  PCNT_ONE = DW'(1);

  logic [NCH*DW-1:0] dly_w;
  logic [NCH-1:0]    mask_q;
  logic [DW-1:0]     period_q;

  logic [2:0]        state_q, state_d;
  logic [NCH*DW-1:0] sh_data_q, sh_data_d;
  logic [NCH-1:0]    sh_en_q, sh_en_d;
  logic [NCH-1:0]    seen_q, seen_d, seen_upd;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [DW-1:0]     pcnt_q, pcnt_d;
  logic              trig_d_q;
  logic              trg;
  logic [NCH-1:0]    start_q, start_d;
  logic              clr_q, clr_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              busy_q;

  // Working delay registers; only LOAD transfers them to the channel-facing shadow.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi = gi + 1) begin : g_dly
      logic [DW-1:0] dly_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          dly_q <= '0;
        end else if (i_wr_en && (i_wr_addr == 4'(gi))) begin
          dly_q <= i_wr_data;
        end
      end
      assign dly_w[gi*DW +: DW] = dly_q;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask_q   <= '0;
      period_q <= '0;
    end else if (i_wr_en) begin
      if (i_wr_addr == 4'(NCH))     mask_q   <= i_wr_data[NCH-1:0];
      if (i_wr_addr == 4'(NCH + 1)) period_q <= i_wr_data;
    end
  end

  assign trg = i_trig & ~trig_d_q;

  always_comb begin
    state_d   = state_q;
    sh_data_d = sh_data_q;
    sh_en_d   = sh_en_q;
    seen_d    = seen_q;
    tcnt_d    = tcnt_q;
    pcnt_d    = pcnt_q;
    start_d   = '0;
    clr_d     = 1'b0;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    err_d     = 1'b0;
    seen_upd  = seen_q | (i_ch_done & sh_en_q);
    if (i_abort) begin
      state_d = S_IDLE;
      clr_d   = (state_q == S_LOAD) || (state_q == S_FIRE) ||
                (state_q == S_WAIT) || (state_q == S_HOLD);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_arm) begin
            if (mask_q != '0) state_d = S_ARMED;
            else              err_d   = 1'b1;
          end
        end
        S_ARMED: begin
          if (trg) state_d = S_LOAD;
        end
        S_LOAD: begin
          sh_data_d = dly_w;
          sh_en_d   = mask_q;
          if (mask_q == '0) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = S_FIRE;
          end
        end
        S_FIRE: begin
          start_d = sh_en_q;
          seen_d  = '0;
          tcnt_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          seen_d = seen_upd;
          if (tcnt_q != TMO_LAST) tcnt_d = tcnt_q + 1'b1;
          // Completion takes priority over a timeout in the same cycle.
          if (seen_upd == sh_en_q) begin
            done_d = 1'b1;
            clr_d  = 1'b1;
            if (period_q == '0) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_HOLD;
              pcnt_d  = period_q;
            end
          end else if (tcnt_q == TMO_LAST) begin
            tmo_d   = 1'b1;
            clr_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_HOLD: begin
          if (pcnt_q == PCNT_ONE) state_d = S_LOAD;
          else                    pcnt_d  = pcnt_q - 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      sh_data_q <= '0;
      sh_en_q   <= '0;
      seen_q    <= '0;
      tcnt_q    <= '0;
      pcnt_q    <= '0;
      trig_d_q  <= 1'b0;
      start_q   <= '0;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_data_q <= sh_data_d;
      sh_en_q   <= sh_en_d;
      seen_q    <= seen_d;
      tcnt_q    <= tcnt_d;
      pcnt_q    <= pcnt_d;
      trig_d_q  <= i_trig;
      start_q   <= start_d;
      clr_q     <= clr_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign o_ch_data  = sh_data_q;
  assign o_ch_en    = sh_en_q;
  assign o_ch_start = start_q;
  assign o_ch_clr   = clr_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_timeout  = tmo_q;
  assign o_err      = err_q;
  assign o_state    = state_q;

endmodule
